// File: rtl/feature_frame_builder.sv
// rtl/feature_frame_builder.sv - I/Q sample quantizer and frame packer for logicnet, saturation selected by FEAT_SATURATE_EN
module feature_frame_builder #(
  parameter int SAMPLE_W  = 16,
  parameter int FEAT_W    = 3,
  parameter int NUM_PAIRS = 8,
  parameter int SHIFT     = 10,
  parameter int SKIP_N    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              trig,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic signed [SAMPLE_W-1:0]        s_i,
  input  logic signed [SAMPLE_W-1:0]        s_q,
  input  logic                              s_last,
  output logic [2*NUM_PAIRS*FEAT_W-1:0]     m_data,
  output logic                              m_valid,
  output logic [7:0]                        m_tag,
  input  logic                              clr_err,
  output logic                              short_err,
  output logic                              retrig_err
);

  localparam int PAIR_W = 2 * FEAT_W;
  localparam int PCW    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [7:0]     SKIP_LAST = (SKIP_N == 0) ? 8'd0 : 8'(SKIP_N - 1);
  localparam logic [PCW-1:0] PAIR_LAST = PCW'(NUM_PAIRS - 1);

  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, EMIT} state_t;

  // With no settling window a trigger goes straight to collection
  localparam state_t START = (SKIP_N == 0) ? COLLECT : SKIP;

  state_t         state;
  logic [7:0]     skip_cnt;
  logic [PCW-1:0] pair_cnt;
  logic [FEAT_W-1:0] qi, qq;

`ifdef FEAT_SATURATE_EN
  localparam logic signed [SAMPLE_W-1:0] QMAX = SAMPLE_W'((2 ** (FEAT_W - 1)) - 1);
  localparam logic signed [SAMPLE_W-1:0] QMIN = SAMPLE_W'(-(2 ** (FEAT_W - 1)));

  function automatic logic [FEAT_W-1:0] sat(input logic signed [SAMPLE_W-1:0] v);
    if (v > QMAX)      return QMAX[FEAT_W-1:0];
    else if (v < QMIN) return QMIN[FEAT_W-1:0];
    else               return v[FEAT_W-1:0];
  endfunction

  logic signed [SAMPLE_W-1:0] sh_i, sh_q;

  // Shift then clamp each component into the feature range
  always_comb begin
    sh_i = s_i >>> SHIFT;
    sh_q = s_q >>> SHIFT;
    qi   = sat(sh_i);
    qq   = sat(sh_q);
  end
`else
  // Shift then keep the low feature bits (two's complement wrap)
  assign qi = FEAT_W'(s_i >>> SHIFT);
  assign qq = FEAT_W'(s_q >>> SHIFT);
`endif

  // Shot sequencing, frame packing, tag and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_tag      <= 8'd0;
      skip_cnt   <= 8'd0;
      pair_cnt   <= '0;
      short_err  <= 1'b0;
      retrig_err <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      // A new error event later in this block overrides the clear
      if (clr_err) begin
        short_err  <= 1'b0;
        retrig_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (trig) begin
            state    <= START;
            s_ready  <= 1'b1;
            skip_cnt <= 8'd0;
            pair_cnt <= '0;
          end
        end
        SKIP: begin
          if (trig) begin
            retrig_err <= 1'b1;
            state      <= START;
            skip_cnt   <= 8'd0;
            pair_cnt   <= '0;
          end else if (s_valid) begin
            skip_cnt <= skip_cnt + 8'd1;
            if (s_last) begin
              short_err <= 1'b1;
              state     <= IDLE;
              s_ready   <= 1'b0;
            end else if (skip_cnt == SKIP_LAST) begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (trig) begin
            retrig_err <= 1'b1;
            state      <= START;
            skip_cnt   <= 8'd0;
            pair_cnt   <= '0;
          end else if (s_valid) begin
            m_data[pair_cnt*PAIR_W +: PAIR_W] <= {qq, qi};
            // Last on the final pair is a normal completion
            if (pair_cnt == PAIR_LAST) begin
              state   <= EMIT;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
            end else if (s_last) begin
              short_err <= 1'b1;
              state     <= IDLE;
              s_ready   <= 1'b0;
            end else begin
              pair_cnt <= pair_cnt + PCW'(1);
            end
          end
        end
        EMIT: begin
          state <= IDLE;
          m_tag <= m_tag + 8'd1;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
